// File: rtl/rv32i_encoder.sv
// RV32I field-bundle to machine-word encoder with a two-entry valid/ready buffer and IMEM address tagging.
// Optional build macro ENCODER_IMM_CHECK_EN adds immediate range checking to the error flag.
module rv32i_encoder #(
    parameter int unsigned ADDR_W = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    input  logic              err_clr
);

    localparam int unsigned IR_W = 32;

`ifdef ENCODER_IMM_CHECK_EN
    localparam bit IMM_CHECK = 1'b1;
`else
    localparam bit IMM_CHECK = 1'b0;
`endif

    localparam logic [3:0] CLS_OP     = 4'd0;
    localparam logic [3:0] CLS_OPIMM  = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_LUI    = 4'd5;
    localparam logic [3:0] CLS_AUIPC  = 4'd6;
    localparam logic [3:0] CLS_JAL    = 4'd7;
    localparam logic [3:0] CLS_JALR   = 4'd8;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [IR_W-1:0] NOP_IR = 32'h0000_0013;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state, next_state;
    logic              accept, deliver;
    logic              load_head_new, load_head_skid, load_skid;
    logic [ADDR_W-1:0] wr_addr;
    logic [IR_W-1:0]   enc_ir, raw_ir;
    logic              illegal, imm_bad, enc_err;
    entry_t            new_e, skid_e;

    // True when v sign-extends cleanly from w bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
        logic [31:0] t;
        t = 32'($signed(v) >>> (w - 1));
        return (t == 32'h0000_0000) || (t == 32'hFFFF_FFFF);
    endfunction

    // Field packing and legality for the bundle currently on the input.
    always_comb begin
        raw_ir  = NOP_IR;
        illegal = 1'b0;
        imm_bad = 1'b0;
        case (in_class)
            CLS_OP: begin
                raw_ir = {1'b0, in_alt, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
                if (in_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101)) illegal = 1'b1;
            end
            CLS_OPIMM: begin
                if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
                    raw_ir  = {1'b0, in_alt, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                    illegal = in_alt && (in_funct3 == 3'b001);
                    imm_bad = |in_imm[31:5];
                end else begin
                    raw_ir  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                    imm_bad = !fits_signed(in_imm, 12);
                end
            end
            CLS_LOAD: begin
                raw_ir  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
                illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
                imm_bad = !fits_signed(in_imm, 12);
            end
            CLS_STORE: begin
                raw_ir  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
                illegal = (in_funct3 > 3'b010);
                imm_bad = !fits_signed(in_imm, 12);
            end
            CLS_BRANCH: begin
                raw_ir  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], OPC_BRANCH};
                illegal = (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
                imm_bad = !fits_signed(in_imm, 13) || in_imm[0];
            end
            CLS_LUI: begin
                raw_ir  = {in_imm[31:12], in_rd, OPC_LUI};
                imm_bad = |in_imm[11:0];
            end
            CLS_AUIPC: begin
                raw_ir  = {in_imm[31:12], in_rd, OPC_AUIPC};
                imm_bad = |in_imm[11:0];
            end
            CLS_JAL: begin
                raw_ir  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                imm_bad = !fits_signed(in_imm, 21) || in_imm[0];
            end
            CLS_JALR: begin
                raw_ir  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_JALR};
                illegal = (in_funct3 != 3'b000);
                imm_bad = !fits_signed(in_imm, 12);
            end
            default: illegal = 1'b1;
        endcase
    end

    assign enc_ir  = illegal ? NOP_IR : raw_ir;
    assign enc_err = illegal || (IMM_CHECK && imm_bad);
    assign new_e   = '{ir: enc_ir, addr: wr_addr};

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_EMPTY;
        else     state <= next_state;
    end

    // Next occupancy and head/skid load steering.
    always_comb begin
        next_state     = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    load_head_new = 1'b1;
                    next_state    = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && deliver) begin
                    load_head_new = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    next_state = S_FULL;
                end else if (deliver) begin
                    next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                if (deliver) begin
                    load_head_skid = 1'b1;
                    if (accept) load_skid = 1'b1;
                    else        next_state = S_ONE;
                end
            end
            default: next_state = S_EMPTY;
        endcase
    end

    // Handshake flags registered from the next occupancy, so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (next_state != S_EMPTY);
            in_ready  <= (next_state != S_FULL);
        end
    end

    // Head (visible output) and skid storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ir   <= '0;
            out_addr <= BASE_ADDR;
            skid_e   <= '{ir: '0, addr: BASE_ADDR};
        end else begin
            if (load_head_new) begin
                out_ir   <= new_e.ir;
                out_addr <= new_e.addr;
            end else if (load_head_skid) begin
                out_ir   <= skid_e.ir;
                out_addr <= skid_e.addr;
            end
            if (load_skid) skid_e <= new_e;
        end
    end

    // Write-address counter, one word per accepted bundle.
    always_ff @(posedge clk) begin
        if (rst)         wr_addr <= BASE_ADDR;
        else if (accept) wr_addr <= wr_addr + ADDR_W'(4);
    end

    // Sticky error; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)                     err <= 1'b0;
        else if (accept && enc_err)  err <= 1'b1;
        else if (err_clr)            err <= 1'b0;
    end

endmodule
